// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add 8-bit multiplier that borrows the shared
// add/shift ALU. In IDLE the execute stage's operands pass straight through.
// While a multiply runs, the sequencer drives the ALU and stalls the execute stage.
// Optional build macro: MUL_SKIP_ZERO_EN visits only the set bits of the multiplier.
module alu_mul_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic       product_zero,
  input  logic [7:0] ex_a,
  input  logic [7:0] ex_b,
  input  logic       ex_ctrl,
  output logic       ex_stall,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_ctrl,
  input  logic [7:0] alu_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ADD   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] a_r, b_r, tmp, acc;
  logic [2:0] idx;
  logic [2:0] start_idx, idx_nxt;
  logic       start_empty, last;

`ifdef MUL_SKIP_ZERO_EN
  // Returns {found, position} of the lowest set bit of v at or above 'from'.
  function automatic logic [3:0] lowest_set(input logic [7:0] v, input logic [3:0] from);
    logic [3:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!r[3] && v[i] && (i >= 32'(from))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  logic [3:0] first_hit, next_hit;

  // Start index and next index come from the set bits of the multiplier.
  always_comb begin
    first_hit   = lowest_set(op_b, 4'd0);
    next_hit    = lowest_set(b_r, {1'b0, idx} + 4'd1);
    start_idx   = first_hit[2:0];
    start_empty = !first_hit[3];
    idx_nxt     = next_hit[2:0];
    last        = !next_hit[3];
  end
`else
  // Fixed walk over all eight multiplier bits.
  always_comb begin
    start_idx   = '0;
    start_empty = 1'b0;
    idx_nxt     = idx + 3'd1;
    last        = (idx == 3'd7);
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and the ALU operand mux (execute-stage passthrough when idle).
  always_comb begin
    state_nxt = state;
    alu_a     = ex_a;
    alu_b     = ex_b;
    alu_ctrl  = ex_ctrl;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start && !start_empty) state_nxt = SHIFT;
      end
      SHIFT: begin
        alu_a     = a_r;
        alu_b     = {5'b0, idx};
        alu_ctrl  = 1'b1;
        state_nxt = ADD;
      end
      ADD: begin
        alu_a     = acc;
        alu_b     = b_r[idx] ? tmp : '0;
        alu_ctrl  = 1'b0;
        state_nxt = last ? IDLE : SHIFT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ex_stall = busy;

  // Operand capture, partial-product accumulation and result/done registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r          <= '0;
      b_r          <= '0;
      tmp          <= '0;
      acc          <= '0;
      idx          <= '0;
      product      <= '0;
      product_zero <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r <= op_a;
            b_r <= op_b;
            acc <= '0;
            idx <= start_idx;
            // Empty multiplier (skip build only): finish without touching the ALU.
            if (start_empty) begin
              product      <= '0;
              product_zero <= 1'b1;
              done         <= 1'b1;
            end
          end
        end
        SHIFT: tmp <= alu_result;
        ADD: begin
          acc <= alu_result;
          if (last) begin
            product      <= alu_result;
            product_zero <= (alu_result == 8'h00);
            done         <= 1'b1;
          end else begin
            idx <= idx_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed vectors for alu_mul_sequencer with a
// behavioural shared ALU. Cycle 0 is the cycle in which start is high.
module tb_alu_mul_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, ex_ctrl;
  logic [7:0] op_a, op_b, ex_a, ex_b;
  logic       busy, done, product_zero, ex_stall, alu_ctrl;
  logic [7:0] product, alu_a, alu_b, alu_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Shared ALU: control 0 adds, control 1 shifts left, both wrap to 8 bits.
  assign alu_result = alu_ctrl ? 8'(alu_a << alu_b) : 8'(alu_a + alu_b);

  alu_mul_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product), .product_zero(product_zero),
    .ex_a(ex_a), .ex_b(ex_b), .ex_ctrl(ex_ctrl), .ex_stall(ex_stall),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] b);
`ifdef MUL_SKIP_ZERO_EN
    return 2 * $countones(b) + 1;
`else
    return 17;
`endif
  endfunction

  function automatic logic [7:0] first_idx(input logic [7:0] b);
`ifdef MUL_SKIP_ZERO_EN
    for (int i = 7; i >= 0; i--) if (b[i]) first_idx = 8'(i);
    if (b == 8'h00) first_idx = 8'h00;
`else
    first_idx = 8'h00;
`endif
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One multiply: start for one cycle, then follow busy/done up to the expected latency.
  task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_p, input logic exp_z);
    int lat;
    lat = exp_lat(b);
    next_cycle();
    start = 1'b1; op_a = a; op_b = b;
    @(negedge clk);
    check_eq({tag, "_c0_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_c0_alu_a"}, 32'(alu_a), 32'(ex_a));
    for (int c = 1; c <= lat; c++) begin
      next_cycle();
      start = 1'b0;
      @(negedge clk);
      if (c == 1 && lat > 1) begin
        check_eq({tag, "_c1_alu_a"}, 32'(alu_a), 32'(a));
        check_eq({tag, "_c1_alu_b"}, 32'(alu_b), 32'(first_idx(b)));
        check_eq({tag, "_c1_alu_ctrl"}, 32'(alu_ctrl), 32'd1);
        check_eq({tag, "_c1_stall"}, 32'(ex_stall), 32'd1);
      end
      check_eq({tag, "_busy"}, 32'(busy), (c < lat) ? 32'd1 : 32'd0);
      check_eq({tag, "_done"}, 32'(done), (c == lat) ? 32'd1 : 32'd0);
    end
    check_eq({tag, "_product"}, 32'(product), 32'(exp_p));
    check_eq({tag, "_pzero"}, 32'(product_zero), 32'(exp_z));
    next_cycle();
    @(negedge clk);
    check_eq({tag, "_done_1cyc"}, 32'(done), 32'd0);
    check_eq({tag, "_product_held"}, 32'(product), 32'(exp_p));
  endtask

  initial begin
    int dones;
    int lat;
    reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    ex_a = 8'd5; ex_b = 8'd3; ex_ctrl = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_product", 32'(product), 32'd0);
    check_eq("rst_pzero", 32'(product_zero), 32'd0);
    check_eq("rst_stall", 32'(ex_stall), 32'd0);

    // Idle passthrough, both control values.
    check_eq("pt_alu_a", 32'(alu_a), 32'd5);
    check_eq("pt_alu_b", 32'(alu_b), 32'd3);
    check_eq("pt_alu_ctrl", 32'(alu_ctrl), 32'd0);
    next_cycle();
    ex_a = 8'hA5; ex_b = 8'h5A; ex_ctrl = 1'b1;
    @(negedge clk);
    check_eq("pt2_alu_a", 32'(alu_a), 32'hA5);
    check_eq("pt2_alu_b", 32'(alu_b), 32'h5A);
    check_eq("pt2_alu_ctrl", 32'(alu_ctrl), 32'd1);
    ex_a = 8'd5; ex_b = 8'd3; ex_ctrl = 1'b0;

    run_mul("m13x11", 8'd13, 8'd11, 8'h8F, 1'b0);
    run_mul("m20x10", 8'h20, 8'h10, 8'h00, 1'b1);
    run_mul("m3x80", 8'd3, 8'h80, 8'h80, 1'b0);
    run_mul("mffxff", 8'hFF, 8'hFF, 8'h01, 1'b0);
    run_mul("m5x0", 8'd5, 8'h00, 8'h00, 1'b1);
    run_mul("m2x3", 8'd2, 8'd3, 8'h06, 1'b0);

    // Reset in cycle 6 abandons the multiply.
    next_cycle();
    start = 1'b1; op_a = 8'd13; op_b = 8'd11;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      start = 1'b0;
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst6_busy", 32'(busy), 32'd0);
    check_eq("rst6_product", 32'(product), 32'd0);
    check_eq("rst6_pzero", 32'(product_zero), 32'd0);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      @(negedge clk);
      if (done) dones++;
    end
    check_eq("rst6_no_done", 32'(dones), 32'd0);
    run_mul("m3x4", 8'd3, 8'd4, 8'd12, 1'b0);

    // start held high; operands changed while busy must be ignored.
    lat = exp_lat(8'd3);
    next_cycle();
    start = 1'b1; op_a = 8'd2; op_b = 8'd3;
    for (int c = 1; c <= 2 * lat; c++) begin
      next_cycle();
      if (c == lat) begin op_a = 8'd2; op_b = 8'd3; end
      else          begin op_a = 8'd9; op_b = 8'd9; end
      @(negedge clk);
      check_eq("hold_done", 32'(done), (c == lat || c == 2 * lat) ? 32'd1 : 32'd0);
      if (c == lat || c == 2 * lat) check_eq("hold_product", 32'(product), 32'd6);
      if (c == lat) check_eq("hold_busy_at_done", 32'(busy), 32'd0);
      if (c == lat + 1) check_eq("hold_busy_after", 32'(busy), 32'd1);
    end
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
